// File: rtl/mvp_pkg.sv
// Shared constants and types for the MxV result collector: padded row count,
// chunk count, FSM state encoding and the bank reset fill value.
package mvp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Value every bank bit takes on reset.
  localparam logic ZERO_FILLING = 1'b0;

  // A full extra granule is appended when NEQ already lands on a granule edge.
  function automatic int unsigned total_rows(input int unsigned neq, input int unsigned pad_to);
    return neq + (pad_to - (neq % pad_to));
  endfunction

  function automatic int unsigned num_chunks(input int unsigned neq, input int unsigned pad_to,
                                             input int unsigned nu);
    return total_rows(neq, pad_to) / nu;
  endfunction

endpackage

// File: rtl/mvp_vec_bank.sv
// One NEQ-element result bank: chunk-indexed masked write of NU rows per
// accept, plus a full flag raised by the frame's last chunk.
module mvp_vec_bank
  import mvp_pkg::*;
#(
  parameter int NEQ   = 10,
  parameter int W     = 32,
  parameter int NU    = 4,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [NU*W-1:0]    data_i,
  input  logic               last_i,
  input  logic               clr_i,
  output logic [NEQ*W-1:0]   vec_o,
  output logic               full_o
);

  logic [NEQ*W-1:0] vec_q;
  logic             full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q  <= {(NEQ*W){ZERO_FILLING}};
      full_q <= 1'b0;
    end else begin
      // Only rows below NEQ have storage; padded tail rows fall away here.
      if (wr_en_i) begin
        for (int r = 0; r < NEQ; r++) begin
          if (idx_i == IDX_W'(r / NU))
            vec_q[(NEQ-1-r)*W +: W] <= data_i[(NU-1-(r % NU))*W +: W];
        end
      end
      if (wr_en_i && last_i)
        full_q <= 1'b1;
      else if (clr_i)
        full_q <= 1'b0;
    end
  end

  assign vec_o  = vec_q;
  assign full_o = full_q;

endmodule

// File: rtl/mvp_result_collector.sv
// Assembles NU-row chunks from the MxV stage into an NEQ-element vector with a
// valid/ack output. Define MVP_COLLECT_DBUF_EN for ping-pong double banking.
module mvp_result_collector
  import mvp_pkg::*;
#(
  parameter int NEQ    = 10,
  parameter int W      = 32,
  parameter int NU     = 4,
  parameter int PAD_TO = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              chunk_valid,
  input  logic [NU*W-1:0]   chunk_data,
  output logic              chunk_ready,
  output logic [NEQ*W-1:0]  vec_out,
  output logic              vec_valid,
  input  logic              vec_ack,
  output logic              overrun
);

  localparam int TOTAL  = int'(total_rows(NEQ, PAD_TO));
  localparam int NCHUNK = int'(num_chunks(NEQ, PAD_TO, NU));
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (TOTAL % NU != 0) begin : g_bad_nu
    $fatal(1, "mvp_result_collector: padded row count not a multiple of NU");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overrun_q, overrun_d;
  logic               accept, last_acc, xfer, free_after;

  assign chunk_ready = start && (state_q == COLLECT);
  assign accept      = chunk_valid && chunk_ready;
  assign last_acc    = accept && (idx_q == IDX_W'(NCHUNK - 1));
  assign xfer        = vec_valid && vec_ack;
  assign overrun     = overrun_q;

`ifdef MVP_COLLECT_DBUF_EN
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       bank_full;
  logic [NEQ*W-1:0] bank_vec [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mvp_vec_bank #(.NEQ(NEQ), .W(W), .NU(NU), .IDX_W(IDX_W)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en_i (accept && (wr_sel_q == 1'(b))),
      .idx_i   (idx_q),
      .data_i  (chunk_data),
      .last_i  (last_acc),
      .clr_i   (!start || (xfer && (rd_sel_q == 1'(b)))),
      .vec_o   (bank_vec[b]),
      .full_o  (bank_full[b])
    );
  end

  // Collection may roll into the other bank if it is empty or is being handed off now.
  assign free_after = !bank_full[~wr_sel_q] || (xfer && (rd_sel_q != wr_sel_q));
  assign vec_valid  = bank_full[rd_sel_q];
  assign vec_out    = bank_vec[rd_sel_q];

  always_comb begin
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (!start) begin
      wr_sel_d = 1'b0;
      rd_sel_d = 1'b0;
    end else begin
      if (last_acc)
        wr_sel_d = ~wr_sel_q;
      if (xfer)
        rd_sel_d = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end
`else
  logic bank_full;

  mvp_vec_bank #(.NEQ(NEQ), .W(W), .NU(NU), .IDX_W(IDX_W)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (accept),
    .idx_i   (idx_q),
    .data_i  (chunk_data),
    .last_i  (last_acc),
    .clr_i   (!start || xfer),
    .vec_o   (vec_out),
    .full_o  (bank_full)
  );

  assign free_after = 1'b0;
  assign vec_valid  = bank_full;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    if (!start) begin
      state_d   = IDLE;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = COLLECT;
          idx_d     = '0;
          overrun_d = 1'b0;
        end
        COLLECT: begin
          if (last_acc && !free_after)
            state_d = HOLD;
        end
        HOLD: begin
          if (xfer)
            state_d = COLLECT;
        end
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && chunk_valid && !chunk_ready)
        overrun_d = 1'b1;
      if (accept)
        idx_d = last_acc ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_mvp_result_collector.sv
// Directed and randomized bench for mvp_result_collector against a row-level
// reference model; expectations follow MVP_COLLECT_DBUF_EN when defined.
module tb_mvp_result_collector;

  localparam int NEQ    = 10;
  localparam int W      = 32;
  localparam int NU     = 4;
  localparam int PAD_TO = 8;
  localparam int TOTAL  = NEQ + (PAD_TO - (NEQ % PAD_TO));
  localparam int NCHUNK = TOTAL / NU;
`ifdef MVP_COLLECT_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef logic [W-1:0] frame_t [TOTAL];

  logic              clk = 1'b0;
  logic              reset, start, chunk_valid, chunk_ready, vec_valid, vec_ack, overrun;
  logic [NU*W-1:0]   chunk_data;
  logic [NEQ*W-1:0]  vec_out;

  int checks = 0;
  int errors = 0;

  frame_t fa, fb;
  logic [NEQ*W-1:0] held;

  mvp_result_collector #(.NEQ(NEQ), .W(W), .NU(NU), .PAD_TO(PAD_TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .chunk_valid (chunk_valid),
    .chunk_data  (chunk_data),
    .chunk_ready (chunk_ready),
    .vec_out     (vec_out),
    .vec_valid   (vec_valid),
    .vec_ack     (vec_ack),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Reference: the vector is simply the first NEQ rows of the frame, row 0 most significant.
  function automatic logic [NEQ*W-1:0] model_vec(input frame_t f);
    logic [NEQ*W-1:0] v;
    v = '0;
    for (int r = 0; r < NEQ; r++) v[(NEQ-1-r)*W +: W] = f[r];
    return v;
  endfunction

  function automatic logic [NU*W-1:0] pack_chunk(input frame_t f, input int k);
    logic [NU*W-1:0] d;
    for (int j = 0; j < NU; j++) d[(NU-1-j)*W +: W] = f[k*NU + j];
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [NEQ*W-1:0] obs, input logic [NEQ*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(output frame_t f, input logic [W-1:0] base);
    for (int r = 0; r < TOTAL; r++) f[r] = base + W'(r);
  endtask

  task automatic fill_rand(output frame_t f);
    for (int r = 0; r < TOTAL; r++) f[r] = $urandom;
  endtask

  // Waits (bounded) for chunk_ready, then drives chunk k without advancing the clock.
  task automatic present_chunk(input frame_t f, input int k);
    int n = 0;
    while (chunk_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk_bit("ready_wait", chunk_ready, 1'b1);
    chunk_data  = pack_chunk(f, k);
    chunk_valid = 1'b1;
  endtask

  task automatic send_chunk(input frame_t f, input int k);
    present_chunk(f, k);
    step();
    chunk_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap);
    for (int k = 0; k < NCHUNK; k++) begin
      send_chunk(f, k);
      repeat (gap) step();
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (vec_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk_bit(tag, vec_valid, 1'b1);
  endtask

  task automatic ack_once();
    vec_ack = 1'b1;
    step();
    vec_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chunk_valid = 1'b0; chunk_data = '0; vec_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    chk_bit("rst_valid", vec_valid, 1'b0);
    chk_bit("rst_overrun", overrun, 1'b0);
    chk_bit("rst_ready", chunk_ready, 1'b0);
    chk_vec("rst_vec", vec_out, '0);

    // Back-to-back frame, exact one-cycle latency after the final accept
    start = 1'b1;
    step();
    chk_bit("t1_ready_collect", chunk_ready, 1'b1);
    fill_seq(fa, 32'h100);
    for (int k = 0; k < NCHUNK - 1; k++) send_chunk(fa, k);
    present_chunk(fa, NCHUNK - 1);
    chk_bit("t1_valid_before", vec_valid, 1'b0);
    step();
    chunk_valid = 1'b0;
    chk_bit("t1_valid_after", vec_valid, 1'b1);
    chk_vec("t1_vec", vec_out, model_vec(fa));
    chk_bit("t1_ready_hold", chunk_ready, DBUF);
    ack_once();
    chk_bit("t1_valid_acked", vec_valid, 1'b0);
    chk_bit("t1_ready_after_ack", chunk_ready, 1'b1);

    // Gapped random frame; a stray ack while nothing is valid must be ignored
    fill_rand(fa);
    for (int k = 0; k < NCHUNK; k++) begin
      send_chunk(fa, k);
      if (k == 1) vec_ack = 1'b1;
      step();
      vec_ack = 1'b0;
      step(); step();
      if (k < NCHUNK - 1) chk_bit("t2_no_early_valid", vec_valid, 1'b0);
    end
    chk_bit("t2_valid", vec_valid, 1'b1);
    chk_vec("t2_vec", vec_out, model_vec(fa));
    ack_once();

    // Held vector plus one extra chunk
    fill_seq(fa, 32'h300);
    send_frame(fa, 0);
    wait_valid("t3_valid");
    held = model_vec(fa);
    repeat (5) step();
    chk_bit("t3_ready", chunk_ready, DBUF);
    fill_seq(fb, 32'h500);
    chunk_data = pack_chunk(fb, 0);
    chunk_valid = 1'b1;
    step();
    chunk_valid = 1'b0;
    chk_bit("t3_overrun", overrun, !DBUF);
    chk_bit("t3_valid_held", vec_valid, 1'b1);
    chk_vec("t3_vec_held", vec_out, held);

    // Abort mid-frame, then a clean frame
    start = 1'b0;
    step();
    chk_bit("t4_idle_overrun", overrun, 1'b0);
    chk_bit("t4_idle_valid", vec_valid, 1'b0);
    chk_bit("t4_idle_ready", chunk_ready, 1'b0);
    start = 1'b1;
    fill_seq(fb, 32'h400);
    send_chunk(fb, 0);
    send_chunk(fb, 1);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk_bit("t4_no_partial_valid", vec_valid, 1'b0);
    fill_seq(fa, 32'h200);
    send_frame(fa, 0);
    chk_bit("t4_valid", vec_valid, 1'b1);
    chk_vec("t4_vec", vec_out, model_vec(fa));
    ack_once();

`ifdef MVP_COLLECT_DBUF_EN
    // Ack of frame A coincides with the last accept of frame B
    fill_rand(fa);
    fill_rand(fb);
    send_frame(fa, 0);
    chk_bit("t6_valid_a", vec_valid, 1'b1);
    for (int k = 0; k < NCHUNK - 1; k++) send_chunk(fb, k);
    chk_vec("t6_vec_a", vec_out, model_vec(fa));
    present_chunk(fb, NCHUNK - 1);
    vec_ack = 1'b1;
    step();
    chunk_valid = 1'b0;
    vec_ack = 1'b0;
    chk_bit("t6_valid_b", vec_valid, 1'b1);
    chk_vec("t6_vec_b", vec_out, model_vec(fb));
    chk_bit("t6_overrun", overrun, 1'b0);
    ack_once();
    chk_bit("t6_drained", vec_valid, 1'b0);
`endif

    // Randomized frames with random gaps and ack delays
    for (int i = 0; i < 4; i++) begin
      fill_rand(fa);
      send_frame(fa, int'($urandom_range(0, 2)));
      wait_valid("rnd_valid");
      repeat ($urandom_range(0, 3)) step();
      chk_vec("rnd_vec", vec_out, model_vec(fa));
      ack_once();
      chk_bit("rnd_acked", vec_valid, 1'b0);
    end
    chk_bit("rnd_overrun", overrun, 1'b0);

    // Reset while a vector is presented
    fill_rand(fa);
    send_frame(fa, 0);
    wait_valid("t5_valid");
    chunk_data = pack_chunk(fa, 0);
    chunk_valid = 1'b1;
    step();
    chunk_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_bit("t5_valid", vec_valid, 1'b0);
    chk_bit("t5_overrun", overrun, 1'b0);
    chk_bit("t5_ready", chunk_ready, 1'b0);
    chk_vec("t5_vec", vec_out, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
